tt_bus_responder: RTL and testbench

Bus-side responder for the `tt_um_warriorjacq9` CPU core. It watches the core's 4-bit BUSREQ code on `uo_out[3:0]` and services each request once:
- instruction fetch and next-operand fetch from a small program memory, driven onto `ui_in`;
- register reads from a 16-entry register file, driven onto `uio_in`.

It replaces the behavioural stimulus around the core and sits beside it in the top-level wrapper.

---
 rtl/tt_bus_responder.sv | 122 ++++++++++++
 tb/tb_tt_bus_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tt_bus_responder.sv
// Bus-side responder for the tt_um_warriorjacq9 core: program fetch and register reads.
// Define BUSRESP_WRITEBACK_EN to implement the REG_WRITE (0100) request.
module tt_bus_responder #(
  parameter int DATA_W     = 4,
  parameter int PROG_DEPTH = 16,
  parameter int NREGS      = 16,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        busreq,
  input  logic [DATA_W-1:0] result_in,
  output logic [7:0]        instr_out,
  output logic [7:0]        data_out,
  output logic              ack,
  output logic              err,
  output logic [AW-1:0]     pc,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [7:0]        prog_data
);

  localparam logic [3:0] REQ_IDLE  = 4'b0000;
  localparam logic [3:0] REQ_RDREG = 4'b0001;
  localparam logic [3:0] REQ_FETCH = 4'b0010;
  localparam logic [3:0] REQ_NEXT  = 4'b0011;
`ifdef BUSRESP_WRITEBACK_EN
  localparam logic [3:0] REQ_WRREG = 4'b0100;
`endif

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic [7:0]        r_mem [PROG_DEPTH];
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [3:0]        r_prev;
  logic [3:0]        r_sel;
  logic              r_state;
  logic [AW-1:0]     r_pc;
  logic [7:0]        r_instr;
  logic [7:0]        r_data;
  logic              r_ack;
  logic              r_err;

  logic [AW-1:0]     w_pc_nxt;
  logic [7:0]        w_byte;
  logic              w_new;

  assign w_pc_nxt = r_pc + 1'b1;
  assign w_byte   = r_mem[w_pc_nxt];

  // A held code is serviced once; a change to another nonzero code is new.
  always_comb begin
    w_new = 1'b0;
    if (r_state == ST_IDLE)
      w_new = (busreq != REQ_IDLE);
    else
      w_new = (busreq != REQ_IDLE) && (busreq != r_prev);
  end

  always_ff @(posedge clk) begin
    if (prog_we && !rst)
      r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= REQ_IDLE;
      r_state <= ST_IDLE;
      r_sel   <= 4'd0;
      r_pc    <= '1;
      r_instr <= 8'd0;
      r_data  <= 8'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      r_prev  <= busreq;
      r_state <= (busreq != REQ_IDLE) ? ST_ACTIVE : ST_IDLE;
      r_ack   <= 1'b0;
      if (w_new) begin
        case (busreq)
          REQ_FETCH: begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_byte;
            r_ack   <= 1'b1;
          end
          REQ_NEXT: begin
            r_pc         <= w_pc_nxt;
            r_instr[7:4] <= w_byte[3:0];
            r_sel        <= w_byte[3:0];
            r_ack        <= 1'b1;
          end
          REQ_RDREG: begin
            r_data <= 8'(r_regs[r_sel]);
            r_ack  <= 1'b1;
          end
`ifdef BUSRESP_WRITEBACK_EN
          REQ_WRREG: begin
            r_regs[r_sel] <= result_in;
            r_ack         <= 1'b1;
          end
`endif
          default: r_err <= 1'b1;
        endcase
      end
    end
  end

`ifndef BUSRESP_WRITEBACK_EN
  logic w_unused;
  assign w_unused = ^result_in;
`endif

  assign instr_out = r_instr;
  assign data_out  = r_data;
  assign ack       = r_ack;
  assign err       = r_err;
  assign pc        = r_pc;

endmodule

// File: tb/tb_tt_bus_responder.sv
// Directed bench for tt_bus_responder: vector table plus wrap/collision/reset sequences.
module tb_tt_bus_responder;

  logic       clk;
  logic       rst;
  logic [3:0] busreq;
  logic [3:0] result_in;
  logic [7:0] instr_out;
  logic [7:0] data_out;
  logic       ack;
  logic       err;
  logic [3:0] pc;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  int checks = 0;
  int errors = 0;

`ifdef BUSRESP_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  tt_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .busreq    (busreq),
    .result_in (result_in),
    .instr_out (instr_out),
    .data_out  (data_out),
    .ack       (ack),
    .err       (err),
    .pc        (pc),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] res;
    logic [7:0] e_instr;
    logic [7:0] e_data;
    logic       e_ack;
    logic       e_err;
    logic [3:0] e_pc;
  } vec_t;

  vec_t vt[$];

  function automatic logic [7:0] mval(int i);
    logic [3:0] n;
    n = 4'(i);
    if (i == 0) return 8'h21;
    if (i == 1) return 8'h01;
    return {n, ~n};
  endfunction

  task automatic add(logic r, logic [3:0] q, logic [3:0] s,
                     logic [7:0] ei, logic [7:0] ed,
                     logic ea, logic ee, logic [3:0] ep);
    vec_t v;
    v.rst = r; v.req = q; v.res = s;
    v.e_instr = ei; v.e_data = ed;
    v.e_ack = ea; v.e_err = ee; v.e_pc = ep;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [7:0] ei, logic [7:0] ed,
                         logic ea, logic ee, logic [3:0] ep);
    chk({nm, "_instr"}, 32'(instr_out), 32'(ei));
    chk({nm, "_data"}, 32'(data_out), 32'(ed));
    chk({nm, "_ack"}, 32'(ack), 32'(ea));
    chk({nm, "_err"}, 32'(err), 32'(ee));
    chk({nm, "_pc"}, 32'(pc), 32'(ep));
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    rst = 1'b1; busreq = 4'd0; result_in = 4'd0;
    prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
    step();
    step();
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 4'hF);

    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = mval(i);
      step();
    end
    prog_we = 1'b0;
    chk("load_pc", 32'(pc), 32'hF);

    d = WB ? 8'h04 : 8'h00;
    e = !WB;
    add(0, 4'h2, 0, 8'h21, 8'h00, 1, 0, 4'd0);
    add(0, 4'h0, 0, 8'h21, 8'h00, 0, 0, 4'd0);
    add(0, 4'h3, 0, 8'h11, 8'h00, 1, 0, 4'd1);
    add(0, 4'h0, 0, 8'h11, 8'h00, 0, 0, 4'd1);
    add(0, 4'h4, 4, 8'h11, 8'h00, WB, e, 4'd1);
    add(0, 4'h1, 0, 8'h11, d, 1, e, 4'd1);
    add(0, 4'h0, 0, 8'h11, d, 0, e, 4'd1);
    add(0, 4'h2, 0, 8'h2D, d, 1, e, 4'd2);
    for (int k = 0; k < 4; k++)
      add(0, 4'h2, 0, 8'h2D, d, 0, e, 4'd2);
    add(0, 4'h0, 0, 8'h2D, d, 0, e, 4'd2);
    add(0, 4'h2, 0, 8'h3C, d, 1, e, 4'd3);
    add(0, 4'h0, 0, 8'h3C, d, 0, e, 4'd3);
    add(0, 4'h7, 0, 8'h3C, d, 0, 1, 4'd3);
    add(0, 4'h0, 0, 8'h3C, d, 0, 1, 4'd3);
    add(1, 4'h2, 0, 8'h00, 8'h00, 0, 0, 4'hF);
    add(1, 4'h2, 0, 8'h00, 8'h00, 0, 0, 4'hF);
    add(0, 4'h2, 0, 8'h21, 8'h00, 1, 0, 4'd0);
    add(0, 4'h2, 0, 8'h21, 8'h00, 0, 0, 4'd0);
    add(0, 4'h0, 0, 8'h21, 8'h00, 0, 0, 4'd0);
    add(0, 4'h1, 0, 8'h21, 8'h00, 1, 0, 4'd0);
    add(0, 4'h0, 0, 8'h21, 8'h00, 0, 0, 4'd0);

    foreach (vt[i]) begin
      rst = vt[i].rst; busreq = vt[i].req; result_in = vt[i].res;
      step();
      chk_all($sformatf("v%0d", i), vt[i].e_instr, vt[i].e_data,
              vt[i].e_ack, vt[i].e_err, vt[i].e_pc);
    end

    // pc wrap across the whole program memory
    rst = 1'b1; busreq = 4'd0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      busreq = 4'h2;
      step();
      chk($sformatf("wrap%0d_pc", i), 32'(pc), 32'(i % 16));
      chk($sformatf("wrap%0d_instr", i), 32'(instr_out), 32'(mval(i % 16)));
      chk($sformatf("wrap%0d_ack", i), 32'(ack), 32'd1);
      busreq = 4'h0;
      step();
    end

    // fetch collides with a write to the same byte
    busreq = 4'h2; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'hC3;
    step();
    prog_we = 1'b0;
    chk("coll_instr", 32'(instr_out), 32'h01);
    chk("coll_pc", 32'(pc), 32'd1);
    busreq = 4'h0;
    step();

    // write attempted during reset must not land
    rst = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hEE;
    step();
    rst = 1'b0; prog_we = 1'b0;
    step();
    busreq = 4'h2;
    step();
    chk("rstwe_instr", 32'(instr_out), 32'h21);
    chk("rstwe_pc", 32'(pc), 32'd0);
    busreq = 4'h0;
    step();
    busreq = 4'h2;
    step();
    chk("landed_instr", 32'(instr_out), 32'hC3);
    chk("landed_pc", 32'(pc), 32'd1);
    busreq = 4'h0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
